// File: rtl/alu_in_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : alu_in_arbiter
//  Purpose  : Round-robin sharing of the ALU command port among NUM_REQ
//             requesters, with ALU reset sequencing and ready-gated issue.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_in_arbiter #(
    parameter int ALU_IN_OP_WIDTH = 8,
    parameter int NUM_REQ         = 4,
    parameter int ALU_RST_CYCLES  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [3*NUM_REQ-1:0]               req_op,
    input  logic [ALU_IN_OP_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [ALU_IN_OP_WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               soft_rst_req,
    output logic                               alu_rst,
    input  logic                               ready,
    output logic                               valid,
    output logic [2:0]                         op,
    output logic [ALU_IN_OP_WIDTH-1:0]         a,
    output logic [ALU_IN_OP_WIDTH-1:0]         b,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic [15:0]                        cmd_count
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_RST_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_rst_load = CNT_W'(ALU_RST_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [ID_W-1:0]  c_last_id  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_RST_SEQ = 2'd0,
        ST_IDLE    = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

    state_t                       state_q,     state_d;
    logic [CNT_W-1:0]             rst_cnt_q,   rst_cnt_d;
    logic [ID_W-1:0]              rr_ptr_q,    rr_ptr_d;
    logic                         alu_rst_q,   alu_rst_d;
    logic                         valid_q,     valid_d;
    logic [NUM_REQ-1:0]           req_ready_q, req_ready_d;
    logic [2:0]                   op_q,        op_d;
    logic [ALU_IN_OP_WIDTH-1:0]   a_q,         a_d;
    logic [ALU_IN_OP_WIDTH-1:0]   b_q,         b_d;
    logic [ID_W-1:0]              grant_id_q,  grant_id_d;
    logic [15:0]                  cmd_count_q, cmd_count_d;

    logic                         w_win_found;
    logic [ID_W-1:0]              w_win_idx;
    logic [NUM_REQ-1:0]           w_win_onehot;
    logic [2:0]                   w_win_op;
    logic [ALU_IN_OP_WIDTH-1:0]   w_win_a;
    logic [ALU_IN_OP_WIDTH-1:0]   w_win_b;
    int                           w_cand;

    // Walk offsets from farthest to nearest so the closest requester at or
    // after the pointer is the last (and therefore winning) assignment.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = int'(rr_ptr_q) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (req_valid[w_cand[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_op     = '0;
        w_win_a      = '0;
        w_win_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == ID_W'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_op        = req_op[3*i +: 3];
                w_win_a         = req_a[ALU_IN_OP_WIDTH*i +: ALU_IN_OP_WIDTH];
                w_win_b         = req_b[ALU_IN_OP_WIDTH*i +: ALU_IN_OP_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        alu_rst_d   = alu_rst_q;
        valid_d     = 1'b0;
        req_ready_d = '0;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        grant_id_d  = grant_id_q;
        cmd_count_d = cmd_count_q;

        // Soft reset outranks any grant; pointer, grant_id and count survive it.
        if (soft_rst_req) begin
            state_d   = ST_RST_SEQ;
            rst_cnt_d = c_rst_load;
            alu_rst_d = 1'b0;
        end else begin
            case (state_q)
                ST_RST_SEQ: begin
                    alu_rst_d = 1'b0;
                    rst_cnt_d = rst_cnt_q - c_cnt_one;
                    if (rst_cnt_q <= c_cnt_one) begin
                        state_d   = ST_IDLE;
                        alu_rst_d = 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (ready && w_win_found) begin
                        state_d     = ST_ISSUE;
                        valid_d     = 1'b1;
                        req_ready_d = w_win_onehot;
                        op_d        = w_win_op;
                        a_d         = w_win_a;
                        b_d         = w_win_b;
                        grant_id_d  = w_win_idx;
                        rr_ptr_d    = (w_win_idx == c_last_id) ? '0 : w_win_idx + ID_W'(1);
                        cmd_count_d = cmd_count_q + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_RST_SEQ;
                    rst_cnt_d = c_rst_load;
                    alu_rst_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RST_SEQ;
            rst_cnt_q   <= c_rst_load;
            rr_ptr_q    <= '0;
            alu_rst_q   <= 1'b0;
            valid_q     <= 1'b0;
            req_ready_q <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            grant_id_q  <= '0;
            cmd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            alu_rst_q   <= alu_rst_d;
            valid_q     <= valid_d;
            req_ready_q <= req_ready_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            grant_id_q  <= grant_id_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    assign alu_rst   = alu_rst_q;
    assign valid     = valid_q;
    assign req_ready = req_ready_q;
    assign op        = op_q;
    assign a         = a_q;
    assign b         = b_q;
    assign grant_id  = grant_id_q;
    assign cmd_count = cmd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_in_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_in_arbiter
//  Purpose  : Self-checking bench for alu_in_arbiter (table + scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_in_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int RC = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [3*N-1:0] req_op = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic           soft_rst_req = 1'b0;
    logic           alu_rst;
    logic           ready = 1'b1;
    logic           valid;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [1:0]     grant_id;
    logic [15:0]    cmd_count;

    alu_in_arbiter #(
        .ALU_IN_OP_WIDTH(W),
        .NUM_REQ        (N),
        .ALU_RST_CYCLES (RC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .soft_rst_req (soft_rst_req),
        .alu_rst      (alu_rst),
        .ready        (ready),
        .valid        (valid),
        .op           (op),
        .a            (a),
        .b            (b),
        .grant_id     (grant_id),
        .cmd_count    (cmd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rv;
        logic [1:0]   exp_id;
    } vec_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   id;
        logic [15:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        tbl[8];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = '0;
    logic        prev_valid = 1'b0;
    int          lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_payload(input int v);
        for (int i = 0; i < N; i++) begin
            req_op[3*i +: 3] = 3'(i + v);
            req_a[W*i +: W]  = 8'(16*v + i + 1);
            req_b[W*i +: W]  = 8'(8'hA5 ^ 8'(16*v + i));
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.op  = req_op[3*id +: 3];
        e.a   = req_a[W*id +: W];
        e.b   = req_b[W*id +: W];
        e.id  = 2'(id);
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (req_ready == '0 && cyc < 20);
    endtask

    task automatic drop_req();
        req_valid = '0;
        @(negedge clk);
    endtask

    // Scoreboard: every valid pulse must match the oldest expected command.
    always @(negedge clk) begin
        if (valid) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                chk("op", op, mon_e.op);
                chk("a", a, mon_e.a);
                chk("b", b, mon_e.b);
                chk("grant_id", grant_id, mon_e.id);
                chk("cmd_count", cmd_count, mon_e.cnt);
                chk("req_ready", req_ready, 4'(1) << mon_e.id);
            end
            chk("valid_one_cycle", prev_valid, 0);
        end else begin
            chk("req_ready_idle", req_ready, 0);
        end
        prev_valid <= valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b1010, 2'd1};
        tbl[1] = '{4'b1010, 2'd3};
        tbl[2] = '{4'b0001, 2'd0};
        tbl[3] = '{4'b0001, 2'd0};
        tbl[4] = '{4'b1100, 2'd2};
        tbl[5] = '{4'b0110, 2'd1};
        tbl[6] = '{4'b1111, 2'd2};
        tbl[7] = '{4'b1000, 2'd3};

        // Reset state and ALU reset sequence.
        #12;
        chk("rst_alu_rst", alu_rst, 0);
        chk("rst_valid", valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_op", op, 0);
        #9 rst = 1'b1;
        @(negedge clk);
        chk("seq_alu_rst_low", alu_rst, 0);
        @(negedge clk);
        chk("seq_alu_rst_high", alu_rst, 1);
        chk("seq_cmd_count", cmd_count, 0);

        // Single command from requester 0.
        req_op[2:0] = 3'b001;
        req_a[7:0]  = 8'h12;
        req_b[7:0]  = 8'h34;
        req_valid   = 4'b0001;
        push_exp(0);
        wait_grant(lat);
        chk("t2_latency", lat, 1);
        drop_req();

        // Asynchronous reset mid-operation clears state without a clock edge.
        #2 rst = 1'b0;
        #1;
        chk("arst_cmd_count", cmd_count, 0);
        chk("arst_alu_rst", alu_rst, 0);
        chk("arst_grant_id", grant_id, 0);
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_seq_low", alu_rst, 0);
        @(negedge clk);
        chk("arst_seq_high", alu_rst, 1);

        // All requesters busy: grants rotate, valid every other cycle.
        load_payload(20);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) push_exp(k % N);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("t3_valid_pattern", valid, 32'(k % 2));
            if (k == 16) req_valid = '0;
        end
        chk("t3_cmd_count", cmd_count, 8);
        @(negedge clk);

        // Table-driven round-robin vectors.
        for (int v = 0; v < 8; v++) begin
            load_payload(v + 1);
            req_valid = tbl[v].rv;
            push_exp(int'(tbl[v].exp_id));
            wait_grant(lat);
            chk("tbl_latency", lat, 1);
            chk("tbl_grant_id", grant_id, tbl[v].exp_id);
            drop_req();
        end

        // ready low blocks issue; grant follows on the edge ready returns.
        load_payload(40);
        ready     = 1'b0;
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_no_valid", valid, 0);
        end
        ready = 1'b1;
        push_exp(2);
        wait_grant(lat);
        chk("t4_latency", lat, 1);
        drop_req();

        // Soft reset on the edge of a would-be grant.
        load_payload(50);
        req_valid    = 4'b0010;
        soft_rst_req = 1'b1;
        @(negedge clk);
        soft_rst_req = 1'b0;
        chk("t5_valid", valid, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_alu_rst_0", alu_rst, 0);
        chk("t5_cmd_count", cmd_count, exp_cnt);
        push_exp(1);
        @(negedge clk);
        chk("t5_alu_rst_1", alu_rst, 0);
        chk("t5_no_valid", valid, 0);
        @(negedge clk);
        chk("t5_alu_rst_high", alu_rst, 1);
        wait_grant(lat);
        chk("t5_latency", lat, 1);
        drop_req();

        // Command counter wrap.
        force dut.cmd_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.cmd_count_q;
        chk("t6_preload", cmd_count, 16'hFFFF);
        exp_cnt   = 16'hFFFF;
        load_payload(60);
        req_valid = 4'b0001;
        push_exp(0);
        wait_grant(lat);
        chk("t6_latency", lat, 1);
        drop_req();
        chk("t6_wrap", cmd_count, 0);

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
